// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the multicycle control unit
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_ADDI,
    ST_WB_I,
    ST_ADDR,
    ST_LW_WAIT,
    ST_LW_WB,
    ST_SW,
    ST_BRANCH,
    ST_JUMP,
    ST_EXC,
    ST_EXC_JMP
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ULA_PASS = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;

  localparam int IORD_PC     = 0;
  localparam int IORD_ALUOUT = 1;

  localparam int REGDST_RT = 0;
  localparam int REGDST_RD = 1;
  localparam int REGDST_RA = 2;

  localparam int MEMTOREG_ALUOUT = 0;
  localparam int MEMTOREG_MDR    = 1;
  localparam int MEMTOREG_PC     = 2;

  localparam int SRCA_PC = 0;
  localparam int SRCA_A  = 1;

  localparam int SRCB_B       = 0;
  localparam int SRCB_FOUR    = 1;
  localparam int SRCB_SEXT    = 2;
  localparam int SRCB_SEXT_SH = 3;

  localparam int PCSRC_ALU    = 0;
  localparam int PCSRC_ALUOUT = 1;
  localparam int PCSRC_JUMP   = 2;
  localparam int PCSRC_EXC    = 3;

  function automatic logic r_funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND);
  endfunction

  function automatic logic [2:0] r_ula(input logic [5:0] f);
    case (f)
      FN_SUB:  return ULA_SUB;
      FN_AND:  return ULA_AND;
      default: return ULA_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// rtl/ctrl_wait_cnt.sv - memory wait counter; done flags the last of MEM_LAT cycles
module ctrl_wait_cnt #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = $clog2(MEM_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt;

  assign done = start && (cnt == LAST);

  // Self-clearing whenever the waiting state is left or finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start && !done) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/ctrl_unit_mc.sv
// rtl/ctrl_unit_mc.sv - multicycle MIPS-subset control FSM
// Define CTRL_UNIT_MC_EXC_EN to enable overflow / invalid-opcode exception handling.
module ctrl_unit_mc
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 3,
  parameter int SEL_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Overflow,
  input  logic             Zero,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic             PC_w,
  output logic             memoria_w,
  output logic             IR_w,
  output logic             reg_w,
  output logic             a_w,
  output logic             b_w,
  output logic             ALUOut_w,
  output logic             MDR_w,
  output logic             EPC_w,
  output logic             exc_cause,
  output logic [2:0]       ula_selector,
  output logic [SEL_W-1:0] iord_s,
  output logic [SEL_W-1:0] regdst_s,
  output logic [SEL_W-1:0] memtoreg_s,
  output logic [SEL_W-1:0] alusrca_s,
  output logic [SEL_W-1:0] alusrcb_s,
  output logic [SEL_W-1:0] pcsrc_s,
  output logic             reset_out
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

`ifdef CTRL_UNIT_MC_EXC_EN
  localparam bit     EXC_ON  = 1'b1;
  localparam state_t ST_TRAP = ST_EXC;
`else
  localparam bit     EXC_ON  = 1'b0;
  localparam state_t ST_TRAP = ST_FETCH;
`endif

  state_t state_q, state_d;
  logic   wait_run, wait_done;
  logic   arith;

  assign wait_run = (state_q == ST_FETCH) || (state_q == ST_LW_WAIT);
  assign arith    = (funct == FN_ADD) || (funct == FN_SUB);

  ctrl_wait_cnt #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) u_wait (
    .clk   (clk),
    .reset (reset),
    .start (wait_run),
    .done  (wait_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

`ifdef CTRL_UNIT_MC_EXC_EN
  logic exc_cause_q;
  // Cause is latched on trap entry: only decode traps for an invalid opcode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  exc_cause_q <= 1'b0;
    else if (state_d == ST_EXC)  exc_cause_q <= (state_q == ST_DECODE);
  end
  assign exc_cause = exc_cause_q;
`else
  assign exc_cause = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:   state_d = ST_FETCH;
      ST_FETCH:   if (wait_done) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_R:          state_d = r_funct_ok(funct) ? ST_EXEC_R : ST_TRAP;
          OP_ADDI:       state_d = ST_ADDI;
          OP_LW, OP_SW:  state_d = ST_ADDR;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_J, OP_JAL:  state_d = ST_JUMP;
          default:       state_d = ST_TRAP;
        endcase
      end
      ST_EXEC_R:  state_d = (EXC_ON && arith && Overflow) ? ST_EXC : ST_WB_R;
      ST_ADDI:    state_d = (EXC_ON && Overflow) ? ST_EXC : ST_WB_I;
      ST_ADDR:    state_d = (opcode == OP_LW) ? ST_LW_WAIT : ST_SW;
      ST_LW_WAIT: if (wait_done) state_d = ST_LW_WB;
      ST_EXC:     state_d = ST_EXC_JMP;
      ST_WB_R, ST_WB_I, ST_LW_WB, ST_SW, ST_BRANCH, ST_JUMP, ST_EXC_JMP:
                  state_d = ST_FETCH;
      default:    state_d = ST_RESET;
    endcase
  end

  always_comb begin
    PC_w         = 1'b0;
    memoria_w    = 1'b0;
    IR_w         = 1'b0;
    reg_w        = 1'b0;
    a_w          = 1'b0;
    b_w          = 1'b0;
    ALUOut_w     = 1'b0;
    MDR_w        = 1'b0;
    EPC_w        = 1'b0;
    reset_out    = 1'b0;
    ula_selector = ULA_PASS;
    iord_s       = SEL_W'(IORD_PC);
    regdst_s     = SEL_W'(REGDST_RT);
    memtoreg_s   = SEL_W'(MEMTOREG_ALUOUT);
    alusrca_s    = SEL_W'(SRCA_PC);
    alusrcb_s    = SEL_W'(SRCB_B);
    pcsrc_s      = SEL_W'(PCSRC_ALU);
    unique case (state_q)
      ST_RESET: reset_out = 1'b1;
      ST_FETCH: if (wait_done) begin
        IR_w         = 1'b1;
        PC_w         = 1'b1;
        alusrcb_s    = SEL_W'(SRCB_FOUR);
        ula_selector = ULA_ADD;
      end
      ST_DECODE: begin
        a_w          = 1'b1;
        b_w          = 1'b1;
        ALUOut_w     = 1'b1;
        alusrcb_s    = SEL_W'(SRCB_SEXT_SH);
        ula_selector = ULA_ADD;
      end
      ST_EXEC_R: begin
        alusrca_s    = SEL_W'(SRCA_A);
        ula_selector = r_ula(funct);
        ALUOut_w     = 1'b1;
      end
      ST_ADDI, ST_ADDR: begin
        alusrca_s    = SEL_W'(SRCA_A);
        alusrcb_s    = SEL_W'(SRCB_SEXT);
        ula_selector = ULA_ADD;
        ALUOut_w     = 1'b1;
      end
      ST_WB_R: begin
        reg_w    = 1'b1;
        regdst_s = SEL_W'(REGDST_RD);
      end
      ST_WB_I: reg_w = 1'b1;
      ST_LW_WAIT: begin
        iord_s = SEL_W'(IORD_ALUOUT);
        MDR_w  = wait_done;
      end
      ST_LW_WB: begin
        reg_w      = 1'b1;
        memtoreg_s = SEL_W'(MEMTOREG_MDR);
      end
      ST_SW: begin
        iord_s    = SEL_W'(IORD_ALUOUT);
        memoria_w = 1'b1;
      end
      ST_BRANCH: begin
        alusrca_s    = SEL_W'(SRCA_A);
        ula_selector = ULA_SUB;
        pcsrc_s      = SEL_W'(PCSRC_ALUOUT);
        PC_w         = (opcode == OP_BEQ) ? Zero : ~Zero;
      end
      ST_JUMP: begin
        PC_w    = 1'b1;
        pcsrc_s = SEL_W'(PCSRC_JUMP);
        if (opcode == OP_JAL) begin
          reg_w      = 1'b1;
          regdst_s   = SEL_W'(REGDST_RA);
          memtoreg_s = SEL_W'(MEMTOREG_PC);
        end
      end
      ST_EXC: begin
        EPC_w        = EXC_ON;
        alusrcb_s    = SEL_W'(SRCB_FOUR);
        ula_selector = ULA_SUB;
      end
      ST_EXC_JMP: begin
        PC_w    = 1'b1;
        pcsrc_s = SEL_W'(PCSRC_EXC);
      end
      default: reset_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// tb/tb_ctrl_unit_mc.sv - self-checking bench for ctrl_unit_mc against an instruction-level model
module tb_ctrl_unit_mc;

  localparam int ML = 3;
`ifdef CTRL_UNIT_MC_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  typedef struct packed {
    logic       pc_w, mem_w, ir_w, reg_w, a_w, b_w, aluout_w, mdr_w, epc_w, exc_cause, rst_o;
    logic [2:0] ula, iord, regdst, memtoreg, srca, srcb, pcsrc;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic Overflow = 1'b0, Zero = 1'b0;
  logic [5:0] opcode = 6'h0, funct = 6'h0;
  logic PC_w, memoria_w, IR_w, reg_w, a_w, b_w, ALUOut_w, MDR_w, EPC_w, exc_cause, reset_out;
  logic [2:0] ula_selector, iord_s, regdst_s, memtoreg_s, alusrca_s, alusrcb_s, pcsrc_s;

  ctrl_unit_mc #(.MEM_LAT(ML), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .Overflow(Overflow), .Zero(Zero), .opcode(opcode), .funct(funct),
    .PC_w(PC_w), .memoria_w(memoria_w), .IR_w(IR_w), .reg_w(reg_w), .a_w(a_w), .b_w(b_w),
    .ALUOut_w(ALUOut_w), .MDR_w(MDR_w), .EPC_w(EPC_w), .exc_cause(exc_cause),
    .ula_selector(ula_selector), .iord_s(iord_s), .regdst_s(regdst_s), .memtoreg_s(memtoreg_s),
    .alusrca_s(alusrca_s), .alusrcb_s(alusrcb_s), .pcsrc_s(pcsrc_s), .reset_out(reset_out)
  );

  always #5 clk = ~clk;

  rec_t act;
  assign act = {PC_w, memoria_w, IR_w, reg_w, a_w, b_w, ALUOut_w, MDR_w, EPC_w, exc_cause, reset_out,
                ula_selector, iord_s, regdst_s, memtoreg_s, alusrca_s, alusrcb_s, pcsrc_s};

  int    total = 0;
  int    bad = 0;
  string tag = "reset";
  rec_t  expq[$];
  rec_t  seq[$];
  logic  m_cause = 1'b0;

  task automatic cmp(input string nm, input rec_t e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s @%0t: got=%h want=%h", nm, $time, act, e);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) cmp(tag, expq.pop_front());
  end

  function automatic rec_t blank();
    rec_t e = '0;
    e.exc_cause = m_cause;
    return e;
  endfunction

  function automatic rec_t rst_rec();
    rec_t e = '0;
    e.rst_o = 1'b1;
    return e;
  endfunction

  task automatic trap(input logic cause);
    rec_t e;
    if (EXC) begin
      m_cause = cause;
      e = blank(); e.epc_w = 1; e.srcb = 1; e.ula = 3'd2; seq.push_back(e);
      e = blank(); e.pc_w = 1; e.pcsrc = 3; seq.push_back(e);
    end
  endtask

  // Expected per-cycle outputs for one whole instruction, from fetch to its last state.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic zr);
    rec_t e;
    seq.delete();
    for (int i = 0; i < ML; i++) begin
      e = blank();
      if (i == ML - 1) begin e.ir_w = 1; e.pc_w = 1; e.srcb = 1; e.ula = 3'd1; end
      seq.push_back(e);
    end
    e = blank(); e.a_w = 1; e.b_w = 1; e.aluout_w = 1; e.srcb = 3; e.ula = 3'd1; seq.push_back(e);
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) begin
          e = blank(); e.srca = 1; e.aluout_w = 1;
          e.ula = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3;
          seq.push_back(e);
          if (EXC && ovf && fn != 6'h24) trap(1'b0);
          else begin e = blank(); e.reg_w = 1; e.regdst = 1; seq.push_back(e); end
        end else trap(1'b1);
      end
      6'h08: begin
        e = blank(); e.srca = 1; e.srcb = 2; e.ula = 3'd1; e.aluout_w = 1; seq.push_back(e);
        if (EXC && ovf) trap(1'b0);
        else begin e = blank(); e.reg_w = 1; seq.push_back(e); end
      end
      6'h23, 6'h2B: begin
        e = blank(); e.srca = 1; e.srcb = 2; e.ula = 3'd1; e.aluout_w = 1; seq.push_back(e);
        if (op == 6'h23) begin
          for (int i = 0; i < ML; i++) begin
            e = blank(); e.iord = 1; e.mdr_w = (i == ML - 1); seq.push_back(e);
          end
          e = blank(); e.reg_w = 1; e.memtoreg = 1; seq.push_back(e);
        end else begin
          e = blank(); e.iord = 1; e.mem_w = 1; seq.push_back(e);
        end
      end
      6'h04, 6'h05: begin
        e = blank(); e.srca = 1; e.ula = 3'd2; e.pcsrc = 1;
        e.pc_w = (op == 6'h04) ? zr : ~zr;
        seq.push_back(e);
      end
      6'h02, 6'h03: begin
        e = blank(); e.pc_w = 1; e.pcsrc = 2;
        if (op == 6'h03) begin e.reg_w = 1; e.regdst = 2; e.memtoreg = 2; end
        seq.push_back(e);
      end
      default: trap(1'b1);
    endcase
  endtask

  task automatic go(input string nm, input logic [5:0] op, input logic [5:0] fn,
                    input logic ovf, input logic zr);
    int n;
    tag = nm; opcode = op; funct = fn; Overflow = ovf; Zero = zr;
    n = seq.size();
    foreach (seq[i]) expq.push_back(seq[i]);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                     input logic ovf, input logic zr);
    build(op, fn, ovf, zr);
    go(nm, op, fn, ovf, zr);
  endtask

  task automatic do_reset();
    tag = "reset";
    reset = 1'b0;
    m_cause = 1'b0;
    #1 cmp("reset_async", rst_rec());
    @(posedge clk); #1;
    expq.push_back(rst_rec());
    @(posedge clk); #1;
    reset = 1'b1;
    expq.push_back(rst_rec());
    @(posedge clk); #1;
  endtask

  function automatic int count_iord(input int v);
    int c = 0;
    foreach (seq[i]) if (seq[i].iord == 3'(v)) c++;
    return c;
  endfunction

  function automatic int count_memw();
    int c = 0;
    foreach (seq[i]) if (seq[i].mem_w) c++;
    return c;
  endfunction

  initial begin
    do_reset();

    build(6'h00, 6'h20, 1'b0, 1'b0);
    chk("add_len", seq.size(), 6);
    chk("add_fetch3", {seq[2].ir_w, seq[2].pc_w}, 3);
    chk("add_wb6", {seq[5].reg_w, seq[5].regdst}, 9);
    go("add", 6'h00, 6'h20, 1'b0, 1'b0);
    run("sub", 6'h00, 6'h22, 1'b0, 1'b1);
    run("and_ovf", 6'h00, 6'h24, 1'b1, 1'b0);

    build(6'h08, 6'h00, 1'b1, 1'b0);
`ifdef CTRL_UNIT_MC_EXC_EN
    chk("addi_ovf_len", seq.size(), 7);
    chk("addi_ovf_epc", {seq[5].epc_w, seq[5].ula}, 10);
    chk("addi_ovf_jmp", {seq[6].pc_w, seq[6].pcsrc}, 11);
    chk("addi_ovf_cause", seq[6].exc_cause, 0);
`else
    chk("addi_ovf_len", seq.size(), 6);
    chk("addi_ovf_wb", seq[5].reg_w, 1);
`endif
    go("addi_ovf", 6'h08, 6'h00, 1'b1, 1'b0);
    run("addi", 6'h08, 6'h11, 1'b0, 1'b0);
    run("add_ovf", 6'h00, 6'h20, 1'b1, 1'b0);

    build(6'h23, 6'h00, 1'b1, 1'b0);
    chk("lw_len", seq.size(), 9);
    chk("lw_iord_cnt", count_iord(1), 3);
    chk("lw_mdr_last", {seq[6].mdr_w, seq[7].mdr_w}, 1);
    chk("lw_wb", {seq[8].reg_w, seq[8].memtoreg}, 9);
    go("lw", 6'h23, 6'h00, 1'b1, 1'b0);

    build(6'h2B, 6'h00, 1'b0, 1'b0);
    chk("sw_memw_once", count_memw(), 1);
    go("sw", 6'h2B, 6'h00, 1'b0, 1'b0);

    build(6'h04, 6'h00, 1'b0, 1'b1);
    chk("beq_taken", {seq[4].pc_w, seq[4].pcsrc}, 9);
    go("beq_z1", 6'h04, 6'h00, 1'b0, 1'b1);
    run("beq_z0", 6'h04, 6'h00, 1'b0, 1'b0);
    build(6'h05, 6'h00, 1'b0, 1'b1);
    chk("bne_not_taken", seq[4].pc_w, 0);
    go("bne_z1", 6'h05, 6'h00, 1'b0, 1'b1);
    run("bne_z0", 6'h05, 6'h00, 1'b0, 1'b0);

    run("j", 6'h02, 6'h00, 1'b0, 1'b0);
    run("jal", 6'h03, 6'h00, 1'b1, 1'b1);

    build(6'h3F, 6'h00, 1'b0, 1'b0);
`ifdef CTRL_UNIT_MC_EXC_EN
    chk("inv_len", seq.size(), 6);
    chk("inv_cause", {seq[4].epc_w, seq[4].exc_cause}, 3);
`else
    chk("inv_len", seq.size(), 4);
`endif
    go("inv_op", 6'h3F, 6'h00, 1'b0, 1'b0);
    run("inv_funct", 6'h00, 6'h21, 1'b0, 1'b0);
    run("add_after_exc", 6'h00, 6'h20, 1'b1, 1'b1);

    build(6'h00, 6'h20, 1'b0, 1'b0);
    tag = "abort"; opcode = 6'h00; funct = 6'h20; Overflow = 1'b0; Zero = 1'b0;
    for (int i = 0; i < ML + 1; i++) expq.push_back(seq[i]);
    repeat (ML) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    do_reset();
    run("add_post_abort", 6'h00, 6'h20, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
